// File: rtl/hamming_tx_if.sv
// Handshake bundle for the Hamming(7,4) transmit stage: nibble input side,
// serial codeword output side, and the sent-frame counter.
interface hamming_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_bit;
  logic       tx_sof;
  logic       tx_eof;
  logic [7:0] frame_cnt;

  // Producer of nibbles / consumer of the serial stream.
  modport master (
    output in_valid, in_data, tx_ready,
    input  in_ready, tx_valid, tx_bit, tx_sof, tx_eof, frame_cnt
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_data, tx_ready,
    output in_ready, tx_valid, tx_bit, tx_sof, tx_eof, frame_cnt
  );
endinterface

// File: rtl/hamming_tx_encoder.sv
// Hamming(7,4) transmit encoder. Nibbles are buffered in a 2-entry FIFO,
// encoded to h[6:0] and shifted out MSB (parity) first, one bit per
// accepted tx handshake. Frames run back-to-back while data is queued.
// Optional feature: define HAM_TX_ERR_INJ_EN to add inj_en/inj_pos, which
// invert one codeword bit chosen at the pop edge (inj_pos=7 means none).
module hamming_tx_encoder (
  input  logic        clk,
  input  logic        rst,
  hamming_tx_if.slave bus
`ifdef HAM_TX_ERR_INJ_EN
  ,
  input  logic        inj_en,
  input  logic [2:0]  inj_pos
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_next;
  logic [3:0] fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count, count_next;
  logic       push, pop;
  logic [2:0] idx, idx_next;
  logic [6:0] sr, sr_next;
  logic       frame_done;
  logic [6:0] inj_mask;
  logic [3:0] head;

  logic       in_ready_q;
  logic       tx_valid_q, tx_bit_q, tx_sof_q, tx_eof_q;
  logic [7:0] frame_cnt_q;

  // Parity bits over the data nibble; data occupies h[3:0].
  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d};
  endfunction

`ifdef HAM_TX_ERR_INJ_EN
  assign inj_mask = (inj_en && inj_pos != 3'd7) ? (7'd1 << inj_pos) : 7'd0;
`else
  assign inj_mask = 7'd0;
`endif

  assign head = fifo_mem[rd_ptr];
  assign push = bus.in_valid && in_ready_q;

  // Next-state, pop decision and shift-register reload for the frame FSM.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    sr_next    = sr;
    pop        = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != 2'd0) begin
          pop        = 1'b1;
          sr_next    = encode(head) ^ inj_mask;
          idx_next   = 3'd6;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // tx_valid is high throughout SHIFT, so tx_ready alone completes a beat.
        if (bus.tx_ready) begin
          if (idx != 3'd0) begin
            idx_next = idx - 3'd1;
          end else begin
            frame_done = 1'b1;
            if (count != 2'd0) begin
              pop      = 1'b1;
              sr_next  = encode(head) ^ inj_mask;
              idx_next = 3'd6;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
    endcase
  end

  // Occupancy after this cycle's push/pop; a push into an empty FIFO is not
  // visible to a pop in the same cycle because pop looks at the current count.
  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Frame datapath, FIFO pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= 3'd0;
      sr          <= 7'd0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      in_ready_q  <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_bit_q    <= 1'b0;
      tx_sof_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      idx         <= idx_next;
      sr          <= sr_next;
      count       <= count_next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      in_ready_q  <= (count_next != 2'd2);
      tx_valid_q  <= (state_next == SHIFT);
      tx_bit_q    <= (state_next == SHIFT) ? sr_next[idx_next] : 1'b0;
      tx_sof_q    <= (state_next == SHIFT) && (idx_next == 3'd6);
      tx_eof_q    <= (state_next == SHIFT) && (idx_next == 3'd0);
      frame_cnt_q <= frame_cnt_q + {7'd0, frame_done};
    end
  end

  // FIFO storage.
  // NOTE: the storage array is not reset; count gates every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_bit    = tx_bit_q;
  assign bus.tx_sof    = tx_sof_q;
  assign bus.tx_eof    = tx_eof_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Self-checking bench for hamming_tx_encoder: random nibbles and tx_ready
// patterns, compared against a codeword model built from the parity rules.
module tb_hamming_tx_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_tx_if bus ();

`ifdef HAM_TX_ERR_INJ_EN
  logic       inj_en  = 1'b0;
  logic [2:0] inj_pos = 3'd0;
`endif

  hamming_tx_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAM_TX_ERR_INJ_EN
    ,
    .inj_en  (inj_en),
    .inj_pos (inj_pos)
`endif
  );

  typedef struct {
    bit b;
    bit sof;
    bit eof;
    int cyc;
  } obs_t;

  obs_t       obs_q[$];
  logic [3:0] acc_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // Record tx beats and accepted nibbles half a cycle before the edge that takes them.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready)
        obs_q.push_back('{bus.tx_bit, bus.tx_sof, bus.tx_eof, cyc});
      if (bus.in_valid && bus.in_ready)
        acc_q.push_back(bus.in_data);
    end
  end

  // Reference codeword: each parity bit is the count of ones in its data subset, mod 2.
  function automatic logic [6:0] ref_code(input logic [3:0] d);
    int p4, p5, p6;
    p4 = (int'(d[0]) + int'(d[1]) + int'(d[3])) % 2;
    p5 = (int'(d[0]) + int'(d[2]) + int'(d[3])) % 2;
    p6 = (int'(d[1]) + int'(d[2]) + int'(d[3])) % 2;
    return {p6[0], p5[0], p4[0], d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer nibbles and drain 7 beats per nibble; stops at a cycle budget.
  task automatic run(input logic [3:0] nibs[$], input int vpct, input int rpct,
                     input int budget, output bit timeout);
    int n, k, c;
    n = nibs.size();
    c = 0;
    timeout = 1'b0;
    forever begin
      k = acc_q.size();
      if (k >= n && obs_q.size() >= 7 * n) break;
      if (c >= budget) begin
        timeout = 1'b1;
        break;
      end
      bus.in_valid = (k < n) && ($urandom_range(99) < vpct);
      bus.in_data  = (k < n) ? nibs[k] : 4'h0;
      bus.tx_ready = ($urandom_range(99) < rpct);
      tick();
      c++;
    end
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    bus.tx_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0 || bus.tx_bit !== 1'b0 ||
        bus.tx_sof !== 1'b0 || bus.tx_eof !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b bit=%b sof=%b eof=%b exp 1 0 0 0 0",
               bus.in_ready, bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof);
    end
    checks++;
    if (bus.frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got=%0d exp=0", bus.frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b exp 1 0", bus.in_ready, bus.tx_valid);
    end
  endtask

  task automatic test_single();
    logic [3:0] nibs[$];
    logic [6:0] w, s, e;
    bit to;
    obs_q.delete();
    acc_q.delete();
    nibs = '{4'b1011};
    bus.tx_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1011;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (acc_q.size() != 1 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got acc=%0d vld=%b exp 1 0", acc_q.size(), bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_sof !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got vld=%b sof=%b exp 1 1", bus.tx_valid, bus.tx_sof);
    end
    run(nibs, 100, 100, 30, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single_timeout got beats=%0d exp 7", obs_q.size());
    end else begin
      w = '0; s = '0; e = '0;
      for (int i = 0; i < 7; i++) begin
        w[6-i] = obs_q[i].b;
        s[6-i] = obs_q[i].sof;
        e[6-i] = obs_q[i].eof;
      end
      checks++;
      if (w !== ref_code(4'b1011)) begin
        errors++;
        $display("FAIL single_word got=%b exp=%b", w, ref_code(4'b1011));
      end
      checks++;
      if (s !== 7'b1000000 || e !== 7'b0000001) begin
        errors++;
        $display("FAIL single_marks got sof=%b eof=%b exp 1000000 0000001", s, e);
      end
    end
    checks++;
    if (bus.frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_frame_cnt got=%0d exp=1", bus.frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] nibs[$];
    logic [6:0] w;
    int k, c, gaps;
    bit to;
    obs_q.delete();
    acc_q.delete();
    nibs = '{4'h0, 4'hF, 4'h6};
    bus.tx_ready = 1'b1;
    k = 0;
    c = 0;
    while (k < 3 && c < 10) begin
      bus.in_valid = 1'b1;
      bus.in_data  = nibs[k];
      tick();
      c++;
      k = acc_q.size();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (k != 3 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got accepted=%0d rdy=%b exp 3 0", k, bus.in_ready);
    end
    run(nibs, 100, 100, 40, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b_timeout got beats=%0d exp 21", obs_q.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        w = '0;
        for (int i = 0; i < 7; i++) w[6-i] = obs_q[7*f+i].b;
        checks++;
        if (w !== ref_code(nibs[f])) begin
          errors++;
          $display("FAIL b2b_word f=%0d got=%b exp=%b", f, w, ref_code(nibs[f]));
        end
      end
      gaps = 0;
      for (int i = 0; i < 20; i++)
        if (obs_q[i+1].cyc != obs_q[i].cyc + 1) gaps++;
      checks++;
      if (gaps != 0) begin
        errors++;
        $display("FAIL b2b_gaps got=%0d exp=0", gaps);
      end
    end
    checks++;
    if (bus.frame_cnt !== 8'd4) begin
      errors++;
      $display("FAIL b2b_frame_cnt got=%0d exp=4", bus.frame_cnt);
    end
  endtask

  task automatic test_stall();
    logic [3:0] nibs[$];
    logic [3:0] d;
    logic [6:0] w, code;
    logic [3:0] snap;
    int c;
    bit to;
    obs_q.delete();
    acc_q.delete();
    d = 4'($urandom_range(15));
    nibs = '{d};
    code = ref_code(d);
    bus.tx_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    c = 0;
    while (obs_q.size() < 3 && c < 20) begin
      tick();
      c++;
      if (acc_q.size() > 0) bus.in_valid = 1'b0;
    end
    bus.tx_ready = 1'b0;
    snap = {bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof};
    checks++;
    if (snap !== {1'b1, code[3], 2'b00}) begin
      errors++;
      $display("FAIL stall_entry got vld/bit/sof/eof=%b exp=%b", snap, {1'b1, code[3], 2'b00});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof} !== snap || obs_q.size() != 3) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got=%b beats=%0d exp=%b beats=3", i,
                 {bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof}, obs_q.size(), snap);
      end
    end
    run(nibs, 100, 100, 20, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL stall_timeout got beats=%0d exp 7", obs_q.size());
    end else begin
      w = '0;
      for (int i = 0; i < 7; i++) w[6-i] = obs_q[i].b;
      checks++;
      if (w !== code) begin
        errors++;
        $display("FAIL stall_word got=%b exp=%b", w, code);
      end
    end
    checks++;
    if (bus.frame_cnt !== 8'd5) begin
      errors++;
      $display("FAIL stall_frame_cnt got=%0d exp=5", bus.frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] nibs[$];
    logic [6:0] code;
    int k, c;
    obs_q.delete();
    acc_q.delete();
    for (int i = 0; i < 3; i++) nibs.push_back(4'($urandom_range(15)));
    code = ref_code(nibs[0]);
    bus.tx_ready = 1'b1;
    c = 0;
    while (obs_q.size() < 2 && c < 30) begin
      k = acc_q.size();
      bus.in_valid = (k < 3);
      bus.in_data  = (k < 3) ? nibs[k] : 4'h0;
      tick();
      c++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc_q.size() != 3 || bus.tx_bit !== code[4] || bus.tx_sof !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_setup got acc=%0d bit=%b sof=%b rdy=%b exp 3 %b 0 0",
               acc_q.size(), bus.tx_bit, bus.tx_sof, bus.in_ready, code[4]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_async got vld=%b rdy=%b cnt=%0d exp 0 1 0",
               bus.tx_valid, bus.in_ready, bus.frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (obs_q.size() != 2 || bus.tx_valid !== 1'b0 || bus.frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_discard got beats=%0d vld=%b cnt=%0d exp 2 0 0",
               obs_q.size(), bus.tx_valid, bus.frame_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] nibs[$];
    logic [6:0] w, s, e;
    int bad_word, bad_mark;
    bit to;
    obs_q.delete();
    acc_q.delete();
    for (int i = 0; i < 256; i++) nibs.push_back(4'($urandom_range(15)));
    run(nibs, 60, 70, 20000, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL wrap_timeout got beats=%0d exp 1792", obs_q.size());
    end else begin
      bad_word = 0;
      bad_mark = 0;
      for (int f = 0; f < 256; f++) begin
        w = '0; s = '0; e = '0;
        for (int i = 0; i < 7; i++) begin
          w[6-i] = obs_q[7*f+i].b;
          s[6-i] = obs_q[7*f+i].sof;
          e[6-i] = obs_q[7*f+i].eof;
        end
        checks++;
        if (w !== ref_code(nibs[f])) begin
          errors++;
          bad_word++;
          if (bad_word <= 5)
            $display("FAIL wrap_word f=%0d got=%b exp=%b", f, w, ref_code(nibs[f]));
        end
        checks++;
        if (s !== 7'b1000000 || e !== 7'b0000001) begin
          errors++;
          bad_mark++;
          if (bad_mark <= 5)
            $display("FAIL wrap_marks f=%0d got sof=%b eof=%b exp 1000000 0000001", f, s, e);
        end
      end
    end
    checks++;
    if (bus.frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_frame_cnt got=%0d exp=0", bus.frame_cnt);
    end
  endtask

`ifdef HAM_TX_ERR_INJ_EN
  task automatic test_inj();
    logic [3:0] nibs[$];
    logic [3:0] d_tab[$];
    logic       en_tab[$];
    logic [2:0] pos_tab[$];
    logic [6:0] w, expw;
    bit to;
    d_tab   = '{4'h5, 4'h5, 4'h5};
    en_tab  = '{1'b1, 1'b1, 1'b0};
    pos_tab = '{3'd2, 3'd7, 3'd3};
    for (int i = 0; i < 8; i++) begin
      d_tab.push_back(4'($urandom_range(15)));
      en_tab.push_back(1'($urandom_range(1)));
      pos_tab.push_back(3'($urandom_range(7)));
    end
    for (int t = 0; t < d_tab.size(); t++) begin
      obs_q.delete();
      acc_q.delete();
      inj_en  = en_tab[t];
      inj_pos = pos_tab[t];
      nibs = '{d_tab[t]};
      expw = ref_code(d_tab[t]);
      if (en_tab[t] && pos_tab[t] <= 3'd6) expw[pos_tab[t]] = ~expw[pos_tab[t]];
      run(nibs, 100, 100, 30, to);
      w = '0;
      if (!to) for (int i = 0; i < 7; i++) w[6-i] = obs_q[i].b;
      checks++;
      if (to || w !== expw) begin
        errors++;
        $display("FAIL inj_word t=%0d d=%h en=%b pos=%0d got=%b exp=%b", t, d_tab[t],
                 en_tab[t], pos_tab[t], w, expw);
      end
    end
    inj_en = 1'b0;
    checks++;
    if (bus.frame_cnt !== 8'(d_tab.size())) begin
      errors++;
      $display("FAIL inj_frame_cnt got=%0d exp=%0d", bus.frame_cnt, d_tab.size());
    end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrap();
`ifdef HAM_TX_ERR_INJ_EN
    test_inj();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
